// File: rtl/ram_bist_pkg.sv
// Shared encodings for the March C- BIST controller.
// Element tables are indexed by the element number (bit e = element e):
//   element 0 {up}(w0), 1 up(r0,w1), 2 up(r1,w0), 3 dn(r0,w1), 4 dn(r1,w0), 5 {up}(r0)
package ram_bist_pkg;

  localparam logic [2:0] E_W0      = 3'd0;
  localparam logic [2:0] E_R0W1    = 3'd1;
  localparam logic [2:0] E_R1W0    = 3'd2;
  localparam logic [2:0] E_R0W1D   = 3'd3;
  localparam logic [2:0] E_R1W0D   = 3'd4;
  localparam logic [2:0] E_R0F     = 3'd5;
  localparam logic [2:0] ELEM_LAST = E_R0F;

  // 1 = sweep D-1 -> 0
  localparam logic [5:0] ELEM_DOWN    = 6'b011000;
  // 1 = read then write per address
  localparam logic [5:0] ELEM_TWO_OPS = 6'b011110;
  // 1 = reads expect ~BG
  localparam logic [5:0] ELEM_RD_INV  = 6'b010100;
  // 1 = writes store ~BG
  localparam logic [5:0] ELEM_WR_INV  = 6'b001010;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Table lookup that yields 0 for the unused element codes 6 and 7.
  function automatic logic elem_bit(input logic [5:0] tbl, input logic [2:0] e);
    return (e <= ELEM_LAST) ? tbl[e] : 1'b0;
  endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Loadable up/down address counter for the BIST sweeps.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_load       reload counter (takes priority over i_step)
//   i_load_down  reload value: 1 = D-1, 0 = 0
//   i_step       advance one address in direction i_down
//   i_down       current sweep direction (also selects the terminal count)
//   o_adr        current address
//   o_tc         current address is the last one of the sweep
module bist_addr_gen #(
  parameter int unsigned N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_load_down,
  input  logic         i_step,
  input  logic         i_down,
  output logic [N-1:0] o_adr,
  output logic         o_tc
);

  logic [N-1:0] r_adr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr <= '0;
    end else if (i_load) begin
      r_adr <= i_load_down ? '1 : '0;
    end else if (i_step) begin
      r_adr <= i_down ? r_adr - 1'b1 : r_adr + 1'b1;
    end
  end

  assign o_adr = r_adr;
  assign o_tc  = i_down ? (r_adr == '0) : (r_adr == '1);

endmodule

// File: rtl/ram_march_bist.sv
// March C- built-in self-test controller driving a RAM with combinational read.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             level request, sampled in IDLE or DONE
//   busy, done, pass  status; pass is meaningful while done=1
//   fail_elem/adr/exp/got  first mismatch: element, address, expected, read word
//   ram_we/adr/din    RAM write enable, address, write data
//   ram_dout          RAM read data for ram_adr
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int unsigned  N  = 6,
  parameter int unsigned  M  = 32,
  parameter logic [M-1:0] BG = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [2:0]   fail_elem,
  output logic [N-1:0] fail_adr,
  output logic [M-1:0] fail_exp,
  output logic [M-1:0] fail_got,
  output logic         ram_we,
  output logic [N-1:0] ram_adr,
  output logic [M-1:0] ram_din,
  input  logic [M-1:0] ram_dout
);

  state_t       r_state, w_state_nxt;
  logic [2:0]   r_elem, w_elem_nxt, w_elem_inc;
  logic         r_op, w_op_nxt;
  logic         r_pass;
  logic [2:0]   r_fail_elem;
  logic [N-1:0] r_fail_adr;
  logic [M-1:0] r_fail_exp, r_fail_got;

  logic         w_run, w_two_ops, w_down, w_tc, w_mis;
  logic         w_load, w_load_down, w_step, w_clear, w_capture, w_finish_ok;
  logic [N-1:0] w_adr;
  logic [M-1:0] w_exp, w_wdat;

  bist_addr_gen #(.N(N)) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_load_down (w_load_down),
    .i_step      (w_step),
    .i_down      (w_down),
    .o_adr       (w_adr),
    .o_tc        (w_tc)
  );

  assign w_run      = (r_state == RUN);
  assign w_two_ops  = elem_bit(ELEM_TWO_OPS, r_elem);
  assign w_down     = elem_bit(ELEM_DOWN, r_elem);
  assign w_elem_inc = r_elem + 3'd1;
  assign w_exp      = elem_bit(ELEM_RD_INV, r_elem) ? ~BG : BG;
  assign w_wdat     = elem_bit(ELEM_WR_INV, r_elem) ? ~BG : BG;
  assign w_mis      = w_run && (r_op == OP_RD) && (ram_dout != w_exp);

  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_op_nxt    = r_op;
    w_load      = 1'b0;
    w_load_down = 1'b0;
    w_step      = 1'b0;
    w_clear     = 1'b0;
    w_capture   = 1'b0;
    w_finish_ok = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_elem_nxt  = E_W0;
          w_op_nxt    = OP_WR;
          w_load      = 1'b1;
          w_clear     = 1'b1;
        end
      end
      RUN: begin
        if (w_mis) begin
          w_state_nxt = DONE;
          w_capture   = 1'b1;
        end else if (w_two_ops && (r_op == OP_RD)) begin
          w_op_nxt = OP_WR;
        end else if (!w_tc) begin
          w_step = 1'b1;
          if (w_two_ops) w_op_nxt = OP_RD;
        end else if (r_elem == ELEM_LAST) begin
          w_state_nxt = DONE;
          w_finish_ok = 1'b1;
        end else begin
          // every element after the first opens with a read
          w_elem_nxt  = w_elem_inc;
          w_op_nxt    = OP_RD;
          w_load      = 1'b1;
          w_load_down = elem_bit(ELEM_DOWN, w_elem_inc);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_elem      <= E_W0;
      r_op        <= OP_RD;
      r_pass      <= 1'b0;
      r_fail_elem <= '0;
      r_fail_adr  <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
      r_op    <= w_op_nxt;
      if (w_clear) begin
        r_pass      <= 1'b0;
        r_fail_elem <= '0;
        r_fail_adr  <= '0;
        r_fail_exp  <= '0;
        r_fail_got  <= '0;
      end else if (w_capture) begin
        r_pass      <= 1'b0;
        r_fail_elem <= r_elem;
        r_fail_adr  <= w_adr;
        r_fail_exp  <= w_exp;
        r_fail_got  <= ram_dout;
      end else if (w_finish_ok) begin
        r_pass <= 1'b1;
      end
    end
  end

  assign busy      = w_run;
  assign done      = (r_state == DONE);
  assign pass      = r_pass;
  assign fail_elem = r_fail_elem;
  assign fail_adr  = r_fail_adr;
  assign fail_exp  = r_fail_exp;
  assign fail_got  = r_fail_got;
  assign ram_we    = w_run && (r_op == OP_WR);
  assign ram_adr   = w_adr;
  assign ram_din   = w_run ? w_wdat : '0;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist with an 8-word RAM model per instance.
// Instance 0 uses BG=0 and can have a fault injected; instance 1 uses BG=AAAA_AAAA.
module tb_ram_march_bist;

  localparam int unsigned N      = 3;
  localparam int unsigned M      = 32;
  localparam int unsigned D      = 8;
  localparam int unsigned RUNLEN = 10 * D;

  typedef struct {
    logic         we;
    logic [N-1:0] adr;
    logic [M-1:0] din;
  } op_t;

  typedef struct {
    logic         pass;
    logic [2:0]   elem;
    logic [N-1:0] adr;
    logic [M-1:0] exp;
    logic [M-1:0] got;
    int unsigned  cycles;
    int unsigned  writes;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n     [2];
  logic         start     [2];
  logic         busy      [2];
  logic         done      [2];
  logic         pass      [2];
  logic [2:0]   fail_elem [2];
  logic [N-1:0] fail_adr  [2];
  logic [M-1:0] fail_exp  [2];
  logic [M-1:0] fail_got  [2];
  logic         ram_we    [2];
  logic [N-1:0] ram_adr   [2];
  logic [M-1:0] ram_din   [2];
  logic [M-1:0] ram_dout  [2];

  int unsigned fault_mode = 0; // 0 none, 1 dout[5] stuck-at-1 at adr 4, 2 writes to 3 alias onto 2

  op_t  trace_q [2][$];
  res_t res_q   [2][$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam logic [M-1:0] BGV = (g == 0) ? 32'h0000_0000 : 32'hAAAA_AAAA;
    logic [M-1:0] mem [D];

    ram_march_bist #(.N(N), .M(M), .BG(BGV)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .start     (start[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .fail_elem (fail_elem[g]),
      .fail_adr  (fail_adr[g]),
      .fail_exp  (fail_exp[g]),
      .fail_got  (fail_got[g]),
      .ram_we    (ram_we[g]),
      .ram_adr   (ram_adr[g]),
      .ram_din   (ram_din[g]),
      .ram_dout  (ram_dout[g])
    );

    always @(posedge clk) begin
      if (ram_we[g]) begin
        mem[ram_adr[g]] <= ram_din[g];
        if (g == 0 && fault_mode == 2 && ram_adr[g] == 3'd3) mem[2] <= ram_din[g];
      end
    end

    assign ram_dout[g] = mem[ram_adr[g]] |
                         ((g == 0 && fault_mode == 1 && ram_adr[g] == 3'd4) ? 32'h0000_0020 : 32'h0);

    // Monitor: per-cycle op trace while busy, result record on each rising done.
    int unsigned bcnt, wcnt, terr, k;
    logic        prev_done, prev_busy;
    op_t         t;
    res_t        r;

    always @(negedge clk) begin
      if (!rst_n[g]) begin
        prev_done = 1'b0;
        prev_busy = 1'b0;
        bcnt = 0; wcnt = 0; terr = 0;
        trace_q[g].delete();
      end else begin
        if (busy[g] && !prev_busy) begin
          bcnt = 0; wcnt = 0; terr = 0;
        end
        if (busy[g]) begin
          bcnt++;
          if (ram_we[g]) wcnt++;
          if (trace_q[g].size() == 0) terr++;
          else begin
            t = trace_q[g].pop_front();
            if (t.we !== ram_we[g] || t.adr !== ram_adr[g] || (t.we && t.din !== ram_din[g])) terr++;
          end
        end
        if (done[g] && !prev_done) begin
          k = bcnt;
          while (k < RUNLEN && trace_q[g].size() > 0) begin
            void'(trace_q[g].pop_front());
            k++;
          end
          if (res_q[g].size() == 0) begin
            check($sformatf("dut%0d unexpected done", g), 64'd1, 64'd0);
          end else begin
            r = res_q[g].pop_front();
            check($sformatf("dut%0d pass", g),        64'(pass[g]),      64'(r.pass));
            check($sformatf("dut%0d fail_elem", g),   64'(fail_elem[g]), 64'(r.elem));
            check($sformatf("dut%0d fail_adr", g),    64'(fail_adr[g]),  64'(r.adr));
            check($sformatf("dut%0d fail_exp", g),    64'(fail_exp[g]),  64'(r.exp));
            check($sformatf("dut%0d fail_got", g),    64'(fail_got[g]),  64'(r.got));
            check($sformatf("dut%0d busy cycles", g), 64'(bcnt),         64'(r.cycles));
            check($sformatf("dut%0d write cycles", g),64'(wcnt),         64'(r.writes));
            check($sformatf("dut%0d op trace errors", g), 64'(terr),     64'd0);
          end
        end
        prev_done = done[g];
        prev_busy = busy[g];
      end
    end
  end

  function automatic res_t mk_res(input logic p, input logic [2:0] e, input logic [N-1:0] a,
                                  input logic [M-1:0] x, input logic [M-1:0] gt,
                                  input int unsigned c, input int unsigned w);
    res_t r;
    r.pass = p; r.elem = e; r.adr = a; r.exp = x; r.got = gt; r.cycles = c; r.writes = w;
    return r;
  endfunction

  // Full March C- op sequence for background bg, then the expected result record.
  task automatic push_run(input int g, input logic [M-1:0] bg, input res_t r);
    op_t o;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < int'(D); i++) begin
        o.adr = (e == 3 || e == 4) ? N'(int'(D) - 1 - i) : N'(i);
        if (e == 0) begin
          o.we = 1'b1; o.din = bg;
          trace_q[g].push_back(o);
        end else begin
          o.we = 1'b0; o.din = '0;
          trace_q[g].push_back(o);
          if (e != 5) begin
            o.we = 1'b1; o.din = (e == 1 || e == 3) ? ~bg : bg;
            trace_q[g].push_back(o);
          end
        end
      end
    end
    res_q[g].push_back(r);
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk); start[g] = 1'b1;
    @(negedge clk); start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int limit);
    logic prev;
    prev = done[g];
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done[g] && !prev) return;
      prev = done[g];
    end
    check($sformatf("dut%0d done timeout", g), 64'd0, 64'd1);
  endtask

  task automatic check_idle_outputs(input int g, input string tag);
    check($sformatf("%s busy", tag),      64'(busy[g]),      64'd0);
    check($sformatf("%s done", tag),      64'(done[g]),      64'd0);
    check($sformatf("%s pass", tag),      64'(pass[g]),      64'd0);
    check($sformatf("%s ram_we", tag),    64'(ram_we[g]),    64'd0);
    check($sformatf("%s ram_adr", tag),   64'(ram_adr[g]),   64'd0);
    check($sformatf("%s ram_din", tag),   64'(ram_din[g]),   64'd0);
    check($sformatf("%s fail_elem", tag), 64'(fail_elem[g]), 64'd0);
    check($sformatf("%s fail_adr", tag),  64'(fail_adr[g]),  64'd0);
    check($sformatf("%s fail_exp", tag),  64'(fail_exp[g]),  64'd0);
    check($sformatf("%s fail_got", tag),  64'(fail_got[g]),  64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned stray;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs(0, "reset dut0");
    check_idle_outputs(1, "reset dut1");
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run: 10*D busy cycles, one write per address in elements 0-4.
    push_run(0, 32'h0, mk_res(1'b1, 3'd0, 3'd0, 32'h0, 32'h0, 80, 40));
    pulse_start(0);
    wait_done(0, 200);
    @(negedge clk);

    // dout[5] stuck-at-1 at adr 4: caught by the first r0 of element 1.
    fault_mode = 1;
    push_run(0, 32'h0, mk_res(1'b0, 3'd1, 3'd4, 32'h0, 32'h0000_0020, 17, 12));
    pulse_start(0);
    wait_done(0, 200);
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (ram_we[0]) stray++;
    end
    check("stuck no write after fail", 64'(stray), 64'd0);
    check("stuck done sticky", 64'(done[0]), 64'd1);

    // Restart from DONE without reset clears pass/fail_*.
    fault_mode = 0;
    push_run(0, 32'h0, mk_res(1'b1, 3'd0, 3'd0, 32'h0, 32'h0, 80, 40));
    pulse_start(0);
    wait_done(0, 200);
    @(negedge clk);

    // Alias 3 -> 2: first visible at the down r0 of adr 2 in element 3.
    fault_mode = 2;
    push_run(0, 32'h0, mk_res(1'b0, 3'd3, 3'd2, 32'h0, 32'hFFFF_FFFF, 51, 29));
    pulse_start(0);
    wait_done(0, 200);
    @(negedge clk);
    fault_mode = 0;

    // Reset during a write op of element 2 (op 31: adr 3, w0).
    pulse_start(0);
    repeat (31) @(posedge clk);
    #1;
    check("midrun ram_we before reset", 64'(ram_we[0]), 64'd1);
    check("midrun busy before reset",   64'(busy[0]),   64'd1);
    #1 rst_n[0] = 1'b0;
    #1;
    check("midrun ram_we async", 64'(ram_we[0]), 64'd0);
    check("midrun busy async",   64'(busy[0]),   64'd0);
    check("midrun done async",   64'(done[0]),   64'd0);
    check("midrun pass async",   64'(pass[0]),   64'd0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    check_idle_outputs(0, "after midrun reset");
    push_run(0, 32'h0, mk_res(1'b1, 3'd0, 3'd0, 32'h0, 32'h0, 80, 40));
    pulse_start(0);
    wait_done(0, 200);
    @(negedge clk);

    // start held high: one-cycle DONE, then an immediate second clean pass.
    push_run(0, 32'h0, mk_res(1'b1, 3'd0, 3'd0, 32'h0, 32'h0, 80, 40));
    push_run(0, 32'h0, mk_res(1'b1, 3'd0, 3'd0, 32'h0, 32'h0, 80, 40));
    @(negedge clk); start[0] = 1'b1;
    wait_done(0, 200);
    @(negedge clk);
    check("held start done one cycle", 64'(done[0]), 64'd0);
    check("held start restarted",      64'(busy[0]), 64'd1);
    wait_done(0, 200);
    start[0] = 1'b0;
    @(negedge clk);
    check("held start second done sticky", 64'(done[0]), 64'd1);

    // Non-zero background: element 0 writes AAAA_AAAA, element 1 writes 5555_5555.
    push_run(1, 32'hAAAA_AAAA, mk_res(1'b1, 3'd0, 3'd0, 32'h0, 32'h0, 80, 40));
    pulse_start(1);
    wait_done(1, 200);
    @(negedge clk);

    check("scoreboard dut0 drained", 64'(res_q[0].size()), 64'd0);
    check("scoreboard dut1 drained", 64'(res_q[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
